// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller:
// FSM state encoding, default width and a counter-width helper.
package serial_adder_ctrl_pkg;

  localparam int SA_N = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit-counter width; never below one bit so N=2 still
  // gets a real register.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// One-bit adder cells: halfadder and a fulladder built from two
// halfadders plus an OR. Ports: x,y,z in; S sum, C carry out.
module halfadder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module fulladder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic S,
  output logic C
);

  logic s0;
  logic c0;
  logic c1;

  halfadder ha0 (
    .x(x),
    .y(y),
    .s(s0),
    .c(c0)
  );

  halfadder ha1 (
    .x(s0),
    .y(z),
    .s(S),
    .c(c1)
  );

  // Both halfadder carries can never be high together,
  // so OR is the full carry.
  assign C = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: LSB-first, one bit per clock.
// In: clk, rst, start, a, b. Out: busy, done, sum, cout.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int N = SA_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = cnt_w(N);

  state_t state;
  state_t state_n;

  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [CW-1:0] cnt;
  logic          carry;

  logic          load;
  logic          step;
  logic          last;
  logic          fa_s;
  logic          fa_c;

  assign last = (cnt == CW'(N - 1));

  fulladder fa (
    .x(sa[0]),
    .y(sb[0]),
    .z(carry),
    .S(fa_s),
    .C(fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (last) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        // A start here is accepted back-to-back.
        if (start) begin
          load    = 1'b1;
          state_n = S_RUN;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // busy/done are flops loaded from the next state so they
  // line up with the state register without output decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      busy <= (state_n == S_RUN);
      done <= (state_n == S_DONE);
      if (load) begin
        sa    <= a;
        sb    <= b;
        cnt   <= '0;
        carry <= 1'b0;
        sum   <= '0;
        cout  <= 1'b0;
      end else if (step) begin
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        cnt   <= cnt + CW'(1);
        carry <= fa_c;
        // New bit enters at the MSB; after N steps the
        // first bit has reached position 0.
        sum   <= {fa_s, sum[N-1:1]};
        if (last) begin
          cout <= fa_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at N=8 and N=4.
// Reference results come from plain integer addition.
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sel;
  logic [31:0] a_in;
  logic [31:0] b_in;

  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  logic        o_busy, o_done, o_cout;
  logic [31:0] o_sum;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [31:0] es;
  logic        ec;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.N(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start & ~sel),
    .a    (a_in[7:0]),
    .b    (b_in[7:0]),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .cout (cout8)
  );

  serial_adder_ctrl #(.N(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .start(start & sel),
    .a    (a_in[3:0]),
    .b    (b_in[3:0]),
    .busy (busy4),
    .done (done4),
    .sum  (sum4),
    .cout (cout4)
  );

  always_comb begin
    o_busy = sel ? busy4 : busy8;
    o_done = sel ? done4 : done8;
    o_cout = sel ? cout4 : cout8;
    o_sum  = sel ? {28'd0, sum4} : {24'd0, sum8};
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues start now and returns at the
  // negedge of the done cycle with start low.
  task automatic add(input int n,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input bit mid,
                     output logic [31:0] r_sum,
                     output logic r_cout);
    logic [31:0] mask;
    logic [32:0] full;
    mask   = (32'd1 << n) - 32'd1;
    full   = {1'b0, x & mask} + {1'b0, y & mask};
    r_sum  = full[31:0] & mask;
    r_cout = full[n];
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= n + 1; k++) begin
      chk("busy", 32'(o_busy), 32'(k <= n));
      chk("done", 32'(o_done), 32'(k == n + 1));
      a_in = $urandom;
      b_in = $urandom;
      if (mid && k == 2) begin
        start = 1'b1;
        a_in  = 32'h10;
        b_in  = 32'h10;
      end
      if (mid && k == 3) start = 1'b0;
      if (k <= n) @(negedge clk);
    end
    chk("sum", o_sum, r_sum);
    chk("cout", 32'(o_cout), 32'(r_cout));
  endtask

  task automatic idle(input int cyc,
                      input logic [31:0] x_sum,
                      input logic x_cout);
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(o_busy), 32'd0);
      chk("idle_done", 32'(o_done), 32'd0);
      chk("hold_sum", o_sum, x_sum);
      chk("hold_cout", 32'(o_cout), 32'(x_cout));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_sum", o_sum, 32'd0);
    chk("rst_cout", 32'(o_cout), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    idle(1, 32'd0, 1'b0);

    add(8, 32'h00, 32'h00, 0, es, ec);
    chk("zero_sum", o_sum, 32'h00);
    idle(1, es, ec);
    add(8, 32'hFF, 32'h01, 0, es, ec);
    chk("ripple_cout", 32'(o_cout), 32'd1);
    idle(1, es, ec);
    add(8, 32'hFF, 32'hFF, 0, es, ec);
    chk("ff_ff_sum", o_sum, 32'hFE);
    idle(1, es, ec);
    add(8, 32'hA5, 32'h5A, 0, es, ec);
    chk("nocarry_sum", o_sum, 32'hFF);
    idle(5, es, ec);
    add(8, 32'h03, 32'h04, 1, es, ec);
    chk("ign_sum", o_sum, 32'h07);
    idle(3, es, ec);

    a_in  = 32'h7F;
    b_in  = 32'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_sum", o_sum, 32'd0);
    chk("abort_cout", 32'(o_cout), 32'd0);
    idle(10, 32'd0, 1'b0);
    add(8, 32'h7F, 32'h01, 0, es, ec);
    chk("after_rst_sum", o_sum, 32'h80);
    idle(1, es, ec);

    add(8, 32'h10, 32'h20, 0, es, ec);
    chk("b2b1_sum", o_sum, 32'h30);
    add(8, 32'hF0, 32'h20, 0, es, ec);
    chk("b2b2_sum", o_sum, 32'h10);
    chk("b2b2_cout", 32'(o_cout), 32'd1);
    idle(2, es, ec);

    for (int s = 0; s < 2; s++) begin
      int n;
      sel = s[0];
      n   = sel ? 4 : 8;
      add(n, 32'hFF, 32'h01, 0, es, ec);
      idle(1, es, ec);
      add(n, 32'hA5, 32'h5A, 0, es, ec);
      add(n, 32'h03, 32'h04, 1, es, ec);
      idle(2, es, ec);
      for (int i = 0; i < 15; i++) begin
        add(n, $urandom, $urandom, $urandom_range(0, 1) == 1, es, ec);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), es, ec);
      end
      idle(2, es, ec);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
